// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Provides the active-low reset level, register bus types, the LLU result
// entry width helper and the write-port grant encoding.
package regfile_wb_arbiter_pkg;

  localparam logic RstEnable = 1'b0;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;
  typedef logic [REG_DATA_W-1:0] reg_bus_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_FIFO
  } grant_e;

  // Width of one buffered LLU result: {waddr, wdata}
  function automatic int unsigned fifo_entry_w(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// rf_result_fifo: synchronous FIFO buffering LLU results for the register
// file write port. Occupancy count, push/pop, no write-to-read bypass.
// Synchronous active-low reset. DEPTH must be a power of two >= 2.
module rf_result_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned W     = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the WB
// stage (fixed priority) and buffered long-latency-unit results. Tracks
// pending LLU destinations in a scoreboard for RAW stalls toward ID and
// requests a pipeline bubble when LLU results starve behind WB.
// Optional macro RF_ARB_SB_BYPASS_EN: raw_stall ignores the scoreboard bit
// of the register being written from the FIFO head this cycle.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = REG_DATA_W,
  parameter int unsigned ADDR_W       = REG_ADDR_W,
  parameter int unsigned REG_NUM      = 2**ADDR_W,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_we,
  input  logic [ADDR_W-1:0]             wb_waddr,
  input  logic [DATA_W-1:0]             wb_wdata,
  input  logic                          llu_valid,
  output logic                          llu_ready,
  input  logic [ADDR_W-1:0]             llu_waddr,
  input  logic [DATA_W-1:0]             llu_wdata,
  input  logic                          iss_valid,
  input  logic [ADDR_W-1:0]             iss_waddr,
  input  logic                          rd_re1,
  input  logic [ADDR_W-1:0]             rd_raddr1,
  input  logic                          rd_re2,
  input  logic [ADDR_W-1:0]             rd_raddr2,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          raw_stall,
  output logic                          pipe_stall_req,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned ENTRY_W = fifo_entry_w(ADDR_W, DATA_W);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SC_W    = $clog2(STARVE_LIMIT + 1);

  logic               run;
  logic               push;
  logic               pop;
  logic               empty;
  logic               full;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic [REG_NUM-1:0] sb;
  logic [REG_NUM-1:0] sb_view;
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] clr_mask;
  logic [SC_W-1:0]    starve;
  grant_e             grant;

  assign run                    = (rst != RstEnable);
  assign {head_addr, head_data} = head;
  assign llu_ready              = run && !full;
  assign push                   = llu_valid && llu_ready;
  assign fifo_count             = run ? count : '0;

  rf_result_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({llu_waddr, llu_wdata}),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Fixed-priority grant: WB cannot be back-pressured, FIFO fills idle slots
  always_comb begin
    grant = GNT_NONE;
    if (run && wb_we)       grant = GNT_WB;
    else if (run && !empty) grant = GNT_FIFO;
  end

  // Drive the write port; an r0 head still pops but suppresses the write
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    pop      = 1'b0;
    unique case (grant)
      GNT_WB: begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end
      GNT_FIFO: begin
        pop      = 1'b1;
        rf_we    = (head_addr != '0);
        rf_waddr = head_addr;
        rf_wdata = head_data;
      end
      default: ;
    endcase
  end

  // Scoreboard update masks; r0 is never marked pending
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && iss_waddr != '0) set_mask = REG_NUM'(1) << iss_waddr;
    if (pop)                          clr_mask = REG_NUM'(1) << head_addr;
  end

  // Pending-destination scoreboard; applying set after clear makes set win
  always_ff @(posedge clk) begin
    if (!run) sb <= '0;
    else      sb <= (sb & ~clr_mask) | set_mask;
  end

  // Scoreboard as seen by the RAW check this cycle
  always_comb begin
    sb_view = sb;
`ifdef RF_ARB_SB_BYPASS_EN
    if (pop) sb_view[head_addr] = 1'b0;
`endif
  end

  assign raw_stall = run && ((rd_re1 && sb_view[rd_raddr1]) ||
                             (rd_re2 && sb_view[rd_raddr2]));

  // Starvation counter: request fires as the count would reach LIMIT-1, then restarts
  always_ff @(posedge clk) begin
    if (!run) begin
      starve         <= '0;
      pipe_stall_req <= 1'b0;
    end else if (wb_we && !empty) begin
      if (32'(starve) + 32'd1 >= STARVE_LIMIT - 32'd1) begin
        starve         <= '0;
        pipe_stall_req <= 1'b1;
      end else begin
        starve         <= starve + SC_W'(1);
        pipe_stall_req <= 1'b0;
      end
    end else begin
      starve         <= '0;
      pipe_stall_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        llu_valid;
  logic        llu_ready;
  logic [4:0]  llu_waddr;
  logic [31:0] llu_wdata;
  logic        iss_valid;
  logic [4:0]  iss_waddr;
  logic        rd_re1;
  logic [4:0]  rd_raddr1;
  logic        rd_re2;
  logic [4:0]  rd_raddr2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        raw_stall;
  logic        pipe_stall_req;
  logic [1:0]  fifo_count;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .llu_valid(llu_valid), .llu_ready(llu_ready),
    .llu_waddr(llu_waddr), .llu_wdata(llu_wdata),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr),
    .rd_re1(rd_re1), .rd_raddr1(rd_raddr1),
    .rd_re2(rd_re2), .rd_raddr2(rd_raddr2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raw_stall(raw_stall), .pipe_stall_req(pipe_stall_req),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk = 0;

  // Reference model: buffered results in arrival order, pending set, denial streak
  logic [36:0] m_q[$];
  bit   [31:0] m_sb;
  int          m_streak;
  bit          m_preq;
  bit          last_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b1; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    llu_valid = 1'b0; llu_waddr = '0; llu_wdata = '0;
    iss_valid = 1'b0; iss_waddr = '0;
    rd_re1 = 1'b0; rd_raddr1 = '0; rd_re2 = 1'b0; rd_raddr2 = '0;
  endtask

  // Mid-cycle comparison of every output against the model
  task automatic settle();
    bit e_ready, e_we, e_raw;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    int          e_cnt;
    bit   [31:0] view;
    #3;
    if (!chk) return;
    e_ready = 0; e_we = 0; e_raw = 0; e_a = '0; e_d = '0; e_cnt = 0;
    if (rst) begin
      view    = m_sb;
      e_ready = (m_q.size() < DEPTH);
      e_cnt   = m_q.size();
      if (wb_we) begin
        e_we = 1; e_a = wb_waddr; e_d = wb_wdata;
      end else if (m_q.size() > 0) begin
        e_a  = m_q[0][36:32];
        e_d  = m_q[0][31:0];
        e_we = (e_a != 0);
`ifdef RF_ARB_SB_BYPASS_EN
        view[e_a] = 1'b0;
`endif
      end
      e_raw = (rd_re1 && view[rd_raddr1]) || (rd_re2 && view[rd_raddr2]);
    end
    check("rf_we", 64'(rf_we), 64'(e_we));
    if (e_we) begin
      check("rf_waddr", 64'(rf_waddr), 64'(e_a));
      check("rf_wdata", 64'(rf_wdata), 64'(e_d));
    end
    check("llu_ready", 64'(llu_ready), 64'(e_ready));
    check("fifo_count", 64'(fifo_count), 64'(e_cnt));
    check("raw_stall", 64'(raw_stall), 64'(e_raw));
    check("pipe_stall_req", 64'(pipe_stall_req), 64'(m_preq));
  endtask

  // Advance the model with the inputs of this cycle, then cross the edge
  task automatic tick();
    bit can_push, denied;
    if (!rst) begin
      m_q.delete(); m_sb = '0; m_streak = 0; m_preq = 0; last_acc = 0;
    end else begin
      can_push = (m_q.size() < DEPTH);
      denied   = wb_we && (m_q.size() > 0);
      last_acc = llu_valid && can_push;
      if (!wb_we && m_q.size() > 0) begin
        m_sb[m_q[0][36:32]] = 1'b0;
        void'(m_q.pop_front());
      end
      if (iss_valid && iss_waddr != 0) m_sb[iss_waddr] = 1'b1;
      if (last_acc) m_q.push_back({llu_waddr, llu_wdata});
      if (denied) begin
        m_streak++;
        m_preq = ((m_streak % (LIMIT - 1)) == 0);
      end else begin
        m_streak = 0;
        m_preq   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Issue, return and write back one LLU result while ID reads its destination
  task automatic llu_flow(input logic [4:0] a, input logic [31:0] d);
    idle(); iss_valid = 1; iss_waddr = a; settle(); tick();
    idle(); llu_valid = 1; llu_waddr = a; llu_wdata = d; rd_re1 = 1; rd_raddr1 = a;
    settle(); check("flow_raw_pending", 64'(raw_stall), 64'(1)); tick();
    idle(); rd_re1 = 1; rd_raddr1 = a; settle();
    check("flow_we", 64'(rf_we), 64'(1));
    check("flow_addr", 64'(rf_waddr), 64'(a));
    check("flow_data", 64'(rf_wdata), 64'(d));
    check("flow_cnt", 64'(fifo_count), 64'(1));
`ifdef RF_ARB_SB_BYPASS_EN
    check("flow_raw_write_cycle", 64'(raw_stall), 64'(0));
`else
    check("flow_raw_write_cycle", 64'(raw_stall), 64'(1));
`endif
    tick();
    idle(); rd_re1 = 1; rd_raddr1 = a; settle();
    check("flow_cnt_after", 64'(fifo_count), 64'(0));
    check("flow_raw_after", 64'(raw_stall), 64'(0));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); rst = 1'b0;
    @(posedge clk); #1;
    chk = 1;
    idle(); rst = 1'b0; settle();
    check("reset_cnt", 64'(fifo_count), 64'(0));
    check("reset_preq", 64'(pipe_stall_req), 64'(0));
    tick();

    llu_flow(5'd5, 32'hDEADBEEF);
    llu_flow(5'd7, 32'h0BADF00D);

    // Starvation: r3 buffered behind continuous WB writes
    idle(); wb_we = 1; wb_waddr = 5'd10; wb_wdata = 32'h1; llu_valid = 1; llu_waddr = 5'd3; llu_wdata = 32'h333;
    settle(); tick();
    for (int i = 1; i <= 4; i++) begin
      idle(); wb_we = 1; wb_waddr = 5'd10; wb_wdata = 32'(i); settle();
      check("starve_preq", 64'(pipe_stall_req), 64'(i == 4));
      tick();
    end
    idle(); settle();
    check("starve_we", 64'(rf_we), 64'(1));
    check("starve_addr", 64'(rf_waddr), 64'(3));
    tick();

    // FIFO full: third result held until the first pop, order preserved
    for (int i = 1; i <= 3; i++) begin
      idle(); wb_we = 1; wb_waddr = 5'd20; llu_valid = 1; llu_waddr = 5'(i); llu_wdata = 32'(100 + i);
      settle(); check("full_ready", 64'(llu_ready), 64'(i < 3)); tick();
    end
    idle(); llu_valid = 1; llu_waddr = 5'd3; llu_wdata = 32'd103; settle();
    check("full_pop1", 64'(rf_waddr), 64'(1));
    check("full_ready_prepop", 64'(llu_ready), 64'(0));
    tick();
    idle(); llu_valid = 1; llu_waddr = 5'd3; llu_wdata = 32'd103; settle();
    check("full_pop2", 64'(rf_waddr), 64'(2));
    tick();
    idle(); settle();
    check("full_pop3", 64'(rf_waddr), 64'(3));
    check("full_pop3_data", 64'(rf_wdata), 64'(103));
    tick();

    // r0 result: popped without a write, scoreboard untouched
    idle(); iss_valid = 1; iss_waddr = 5'd12; settle(); tick();
    idle(); llu_valid = 1; llu_waddr = 5'd0; llu_wdata = 32'h1234; iss_valid = 1; iss_waddr = 5'd0;
    settle(); tick();
    idle(); rd_re1 = 1; rd_raddr1 = 5'd0; rd_re2 = 1; rd_raddr2 = 5'd12; settle();
    check("r0_we", 64'(rf_we), 64'(0));
    check("r0_cnt", 64'(fifo_count), 64'(1));
    tick();
    idle(); rd_re1 = 1; rd_raddr1 = 5'd0; settle();
    check("r0_cnt_after", 64'(fifo_count), 64'(0));
    check("r0_raw", 64'(raw_stall), 64'(0));
    tick();

    // Reset with two entries buffered and r9 pending
    idle(); iss_valid = 1; iss_waddr = 5'd9; settle(); tick();
    idle(); wb_we = 1; llu_valid = 1; llu_waddr = 5'd1; llu_wdata = 32'hA; settle(); tick();
    idle(); wb_we = 1; llu_valid = 1; llu_waddr = 5'd2; llu_wdata = 32'hB; settle(); tick();
    idle(); wb_we = 1; settle();
    check("rst_pre_cnt", 64'(fifo_count), 64'(2));
    tick();
    idle(); rst = 1'b0; rd_re1 = 1; rd_raddr1 = 5'd9; settle();
    check("rst_in_raw", 64'(raw_stall), 64'(0));
    tick();
    idle(); rd_re1 = 1; rd_raddr1 = 5'd9; settle();
    check("rst_cnt", 64'(fifo_count), 64'(0));
    check("rst_raw", 64'(raw_stall), 64'(0));
    check("rst_we", 64'(rf_we), 64'(0));
    check("rst_preq", 64'(pipe_stall_req), 64'(0));
    tick();

    // Randomized traffic honouring the LLU hold and stall contracts
    idle();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 59) != 0);
      wb_we    = !m_preq && ($urandom_range(0, 1) == 1);
      wb_waddr = 5'($urandom);
      wb_wdata = $urandom;
      if (!llu_valid || last_acc) begin
        llu_valid = ($urandom_range(0, 2) != 0);
        llu_waddr = 5'($urandom);
        llu_wdata = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_waddr = 5'($urandom);
      rd_re1    = ($urandom_range(0, 1) == 1);
      rd_raddr1 = 5'($urandom);
      rd_re2    = ($urandom_range(0, 1) == 1);
      rd_raddr2 = 5'($urandom);
      settle();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single general-register-file write port between the pipeline WB stage and a long-latency unit (LLU: multi-cycle mult/div).
- Buffers LLU results in a small FIFO and tracks pending LLU destinations in a 32-bit scoreboard.
- Raises a RAW stall toward ID and a starvation stall toward the pipeline control.
- Sits between MEM/WB, the LLU and the register file write port.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- REG_NUM, 32, number of architectural registers (2**ADDR_W)
- FIFO_DEPTH, 2, LLU result buffer entries; power of two, >=2
- STARVE_LIMIT, 4, consecutive denied cycles before a pipeline stall request; >=1

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- wb_we  in  1  WB stage write request; cannot be back-pressured
- wb_waddr  in  ADDR_W  WB destination register
- wb_wdata  in  DATA_W  WB write data
- llu_valid  in  1  LLU result valid
- llu_ready  out  1  FIFO can accept (count < FIFO_DEPTH)
- llu_waddr  in  ADDR_W  LLU result destination
- llu_wdata  in  DATA_W  LLU result data
- iss_valid  in  1  LLU operation issued this cycle
- iss_waddr  in  ADDR_W  destination of issued LLU operation
- rd_re1 / rd_re2  in  1  ID read enables
- rd_raddr1 / rd_raddr2  in  ADDR_W  ID read addresses
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- raw_stall  out  1  ID reads a pending LLU destination
- pipe_stall_req  out  1  registered; forces a WB bubble next cycle
- fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst==0 at clk edge): FIFO emptied, scoreboard = 0, starve counter = 0, pipe_stall_req = 0.
- Reset values of combinational outputs while rst==0: rf_we=0, raw_stall=0, llu_ready=0, fifo_count=0. Reset mid-operation discards buffered LLU results.
- LLU accept: llu_valid && llu_ready pushes {waddr, wdata} at the clock edge. There is no bypass; a result reaches the write port no earlier than the cycle after acceptance.
- Port arbitration is combinational and fixed-priority:
  - wb_we=1: rf_* = WB values; FIFO holds.
  - else if FIFO non-empty: rf_* = FIFO head; head pops at the edge.
  - else rf_we=0.
- Head entry with waddr==0 pops with rf_we=0 and consumes a grant slot.
- Scoreboard:
  - iss_valid sets bit iss_waddr, except register 0, which is never set.
  - A popped FIFO head clears its bit.
  - Set and clear of the same bit in the same cycle: set wins.
  - WB writes never clear bits.
- raw_stall = (rd_re1 && sb[rd_raddr1]) || (rd_re2 && sb[rd_raddr2]). Combinational from the registered scoreboard.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and wb_we=1; otherwise resets to 0.
  - When the counter reaches STARVE_LIMIT-1 while incrementing, pipe_stall_req is set for exactly one cycle and the counter clears.
- Pipeline contract: while pipe_stall_req=1, wb_we=0. If wb_we=1 anyway, WB still wins; no state corruption.
- FIFO full: llu_ready=0. The LLU holds its result; data must be stable until accepted.
- Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop when full: the push is refused, because llu_ready is computed from the pre-pop count.

Optional Feature:
- Macro RF_ARB_SB_BYPASS_EN.
- Defined: raw_stall ignores a scoreboard bit whose register is being written from the FIFO head this cycle. The regfile's internal write-to-read forwarding supplies the value, saving one stall cycle.
- Undefined: raw_stall uses the registered scoreboard only; the stall lasts until the cycle after the write.

Decomposition:
- Shared defines file gains:
  - RstEnable redefined consistently for active-low (1'b0)
  - RegAddrBus / RegBus reuse
  - FIFO entry width constant (ADDR_W+DATA_W)
- One sub-module, rf_result_fifo: synchronous FIFO with count, push/pop, no bypass.
- Arbitration, scoreboard and starve counter stay in the top.

Test Plan:
- Reset then LLU push {r5, 0xDEADBEEF} with wb_we=0 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF on the next cycle; sb[5] clears; fifo_count returns to 0.
- iss_valid r7, then rd_re1 rd_raddr1=7 -> raw_stall=1 until the r7 result is written. With RF_ARB_SB_BYPASS_EN, raw_stall=0 in the write cycle; without it, raw_stall=1 in that cycle.
- FIFO holds r3 while wb_we=1 continuously with STARVE_LIMIT=4 -> pipe_stall_req=1 in the 4th denied cycle; bench drops wb_we next cycle; r3 written in that cycle.
- Two LLU pushes with WB busy (FIFO_DEPTH=2) -> llu_ready=0; third result held until the first pop; order r1, r2, r3 preserved.
- LLU result to r0 -> no rf_we, entry popped, scoreboard unchanged; iss_valid r0 never sets a bit.
- rst=0 asserted with 2 entries buffered and sb[9]=1 -> next cycle fifo_count=0, raw_stall=0 for r9, rf_we=0, pipe_stall_req=0.
